fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_pkg.sv | 17 +
 rtl/flush_timer.sv | 39 +++
 rtl/fetch_sequencer.sv | 130 +++++++++++++
 tb/tb_fetch_sequencer.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the fetch sequencer.
package fetch_pkg;

  localparam int unsigned PC_WIDTH_DEF     = 18;
  localparam int unsigned FLUSH_CYCLES_DEF = 2;
  localparam int unsigned FLUSH_CNT_W      = 3;
  localparam int unsigned FETCH_CNT_W      = 32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RUN      = 3'd1,
    ST_REDIRECT = 3'd2,
    ST_FLUSH    = 3'd3,
    ST_HALT     = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/flush_timer.sv
// Down-counter that times the flush window following a redirect.
module flush_timer
  import fetch_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   load,
  input  logic [FLUSH_CNT_W-1:0] load_value,
  input  logic                   decrement,
  output logic [FLUSH_CNT_W-1:0] count,
  output logic                   last
);

  logic [FLUSH_CNT_W-1:0] count_q;
  logic [FLUSH_CNT_W-1:0] count_d;

  // Load wins over decrement; never wrap below zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (decrement && (count_q != '0)) begin
      count_d = count_q - FLUSH_CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign last  = (count_q == FLUSH_CNT_W'(1));

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage control FSM: PC enable/select, redirect flushes and halt.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned PC_WIDTH     = PC_WIDTH_DEF,
  parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stall_req,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  input  logic                   halt_detected,
  output logic                   pc_enable,
  output logic                   pc_select,
  output logic [PC_WIDTH-1:0]    new_pc,
  output logic                   flush,
  output logic                   halted,
  output logic [FETCH_CNT_W-1:0] fetch_count
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
  localparam bit                     ONE_CYCLE  = (FLUSH_CYCLES == 1);

  fetch_state_e           state_q, state_d;
  logic [PC_WIDTH-1:0]    target_q, target_d;
  logic [FETCH_CNT_W-1:0] fetch_count_q, fetch_count_d;

  logic                   timer_load;
  logic                   timer_dec;
  logic [FLUSH_CNT_W-1:0] timer_count;
  logic                   timer_last;

  flush_timer u_flush_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (timer_load),
    .load_value (FLUSH_LOAD),
    .decrement  (timer_dec),
    .count      (timer_count),
    .last       (timer_last)
  );

  // Next-state logic: halt beats branch beats normal progression.
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN, ST_REDIRECT, ST_FLUSH: begin
        if (halt_detected) begin
          state_d = ST_HALT;
        end else if (branch_taken) begin
          state_d    = ST_REDIRECT;
          target_d   = branch_target;
          timer_load = 1'b1;
        end else if (state_q == ST_REDIRECT) begin
          state_d = ONE_CYCLE ? ST_RUN : ST_FLUSH;
        end else if (state_q == ST_FLUSH) begin
          timer_dec = (timer_count != '0);
          if (timer_last) state_d = ST_RUN;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from state and stall only.
  always_comb begin
    pc_enable = 1'b0;
    pc_select = 1'b0;
    flush     = 1'b0;
    halted    = 1'b0;
    case (state_q)
      ST_RUN: begin
        pc_enable = !stall_req;
      end
      ST_REDIRECT: begin
        pc_enable = 1'b1;
        pc_select = 1'b1;
        flush     = 1'b1;
      end
      ST_FLUSH: begin
        pc_enable = !stall_req;
        flush     = 1'b1;
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: begin
        pc_enable = 1'b0;
      end
    endcase
  end

  // Saturating count of enabled fetch cycles.
  always_comb begin
    fetch_count_d = fetch_count_q;
    if (pc_enable && (fetch_count_q != '1)) begin
      fetch_count_d = fetch_count_q + FETCH_CNT_W'(1);
    end
  end

  // State, target and counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      target_q      <= '0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign new_pc      = target_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed, table-driven bench for fetch_sequencer (FLUSH_CYCLES=2).
module tb_fetch_sequencer;

  localparam int unsigned PW = 18;

  typedef struct {
    string       name;
    logic        rst;
    logic        st;
    logic        stl;
    logic        br;
    logic [PW-1:0] tgt;
    logic        hlt;
    logic        chk;
    logic        e_en;
    logic        e_sel;
    logic [PW-1:0] e_npc;
    logic        e_fl;
    logic        e_hl;
    logic [31:0] e_cnt;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset, start, stall_req, branch_taken, halt_detected;
  logic [PW-1:0] branch_target;
  logic          pc_enable, pc_select, flush, halted;
  logic [PW-1:0] new_pc;
  logic [31:0]   fetch_count;

  int n_checks = 0;
  int n_pass   = 0;
  vec_t vecs[$];

  fetch_sequencer #(.PC_WIDTH(PW), .FLUSH_CYCLES(2)) dut (
    .clock         (clk),
    .reset         (reset),
    .start         (start),
    .stall_req     (stall_req),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halt_detected (halt_detected),
    .pc_enable     (pc_enable),
    .pc_select     (pc_select),
    .new_pc        (new_pc),
    .flush         (flush),
    .halted        (halted),
    .fetch_count   (fetch_count)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(string name, logic rst, logic st, logic stl, logic br,
                              logic [PW-1:0] tgt, logic hlt, logic chk, logic en,
                              logic sel, logic [PW-1:0] npc, logic fl, logic hl,
                              logic [31:0] cnt);
    vec_t v;
    v.name = name; v.rst = rst; v.st = st; v.stl = stl; v.br = br; v.tgt = tgt;
    v.hlt = hlt; v.chk = chk; v.e_en = en; v.e_sel = sel; v.e_npc = npc;
    v.e_fl = fl; v.e_hl = hl; v.e_cnt = cnt;
    return v;
  endfunction

  task automatic chk1(string nm, string sig, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s %s got=%0h expected=%0h", nm, sig, got, exp);
  endtask

  // Drive one cycle's inputs after the falling edge, then check outputs.
  task automatic apply(vec_t v);
    @(negedge clk);
    reset         = v.rst;
    start         = v.st;
    stall_req     = v.stl;
    branch_taken  = v.br;
    branch_target = v.tgt;
    halt_detected = v.hlt;
    #1;
    if (v.chk) begin
      chk1(v.name, "pc_enable",   32'(pc_enable),   32'(v.e_en));
      chk1(v.name, "pc_select",   32'(pc_select),   32'(v.e_sel));
      chk1(v.name, "new_pc",      32'(new_pc),      32'(v.e_npc));
      chk1(v.name, "flush",       32'(flush),       32'(v.e_fl));
      chk1(v.name, "halted",      32'(halted),      32'(v.e_hl));
      chk1(v.name, "fetch_count", fetch_count,      v.e_cnt);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stall_req = 1'b0; branch_taken = 1'b0;
    branch_target = '0; halt_detected = 1'b0;

    //                 name      rst st stl br tgt     hlt chk en sel npc     fl hl cnt
    vecs.push_back(mk("c00_rst",  1, 0, 0, 0, 18'h000, 0, 0, 0, 0, 18'h000, 0, 0, 0));
    vecs.push_back(mk("c01_idle", 0, 0, 0, 0, 18'h000, 0, 1, 0, 0, 18'h000, 0, 0, 0));
    vecs.push_back(mk("c02_hlt",  0, 0, 0, 0, 18'h000, 1, 1, 0, 0, 18'h000, 0, 0, 0));
    vecs.push_back(mk("c03_start",0, 1, 0, 0, 18'h000, 0, 1, 0, 0, 18'h000, 0, 0, 0));
    vecs.push_back(mk("c04_run",  0, 0, 0, 0, 18'h000, 0, 1, 1, 0, 18'h000, 0, 0, 0));
    vecs.push_back(mk("c05_run",  0, 0, 0, 0, 18'h000, 0, 1, 1, 0, 18'h000, 0, 0, 1));
    vecs.push_back(mk("c06_run",  0, 0, 0, 0, 18'h000, 0, 1, 1, 0, 18'h000, 0, 0, 2));
    vecs.push_back(mk("c07_run",  0, 0, 0, 0, 18'h000, 0, 1, 1, 0, 18'h000, 0, 0, 3));
    vecs.push_back(mk("c08_run",  0, 0, 0, 0, 18'h000, 0, 1, 1, 0, 18'h000, 0, 0, 4));
    vecs.push_back(mk("c09_stl",  0, 0, 1, 0, 18'h000, 0, 1, 0, 0, 18'h000, 0, 0, 5));
    vecs.push_back(mk("c10_stl",  0, 0, 1, 0, 18'h000, 0, 1, 0, 0, 18'h000, 0, 0, 5));
    vecs.push_back(mk("c11_stl",  0, 0, 1, 0, 18'h000, 0, 1, 0, 0, 18'h000, 0, 0, 5));
    vecs.push_back(mk("c12_run",  0, 0, 0, 0, 18'h000, 0, 1, 1, 0, 18'h000, 0, 0, 5));
    vecs.push_back(mk("c13_br",   0, 0, 1, 1, 18'h0A5, 0, 1, 0, 0, 18'h000, 0, 0, 6));
    vecs.push_back(mk("c14_redir",0, 0, 1, 0, 18'h000, 0, 1, 1, 1, 18'h0A5, 1, 0, 6));
    vecs.push_back(mk("c15_flush",0, 0, 0, 0, 18'h000, 0, 1, 1, 0, 18'h0A5, 1, 0, 7));
    vecs.push_back(mk("c16_br",   0, 0, 0, 1, 18'h033, 0, 1, 1, 0, 18'h0A5, 0, 0, 8));
    vecs.push_back(mk("c17_redir",0, 0, 0, 0, 18'h000, 0, 1, 1, 1, 18'h033, 1, 0, 9));
    vecs.push_back(mk("c18_fl_br",0, 0, 0, 1, 18'h100, 0, 1, 1, 0, 18'h033, 1, 0, 10));
    vecs.push_back(mk("c19_redir",0, 0, 0, 0, 18'h000, 0, 1, 1, 1, 18'h100, 1, 0, 11));
    vecs.push_back(mk("c20_flush",0, 0, 0, 0, 18'h000, 0, 1, 1, 0, 18'h100, 1, 0, 12));
    vecs.push_back(mk("c21_hltbr",0, 0, 0, 1, 18'h2AA, 1, 1, 1, 0, 18'h100, 0, 0, 13));
    vecs.push_back(mk("c22_halt", 0, 1, 0, 0, 18'h000, 0, 1, 0, 0, 18'h100, 0, 1, 14));
    vecs.push_back(mk("c23_halt", 0, 1, 0, 1, 18'h3FF, 0, 1, 0, 0, 18'h100, 0, 1, 14));
    vecs.push_back(mk("c24_hrst", 1, 1, 0, 0, 18'h000, 0, 1, 0, 0, 18'h100, 0, 1, 14));
    vecs.push_back(mk("c25_idle", 0, 1, 0, 0, 18'h000, 0, 1, 0, 0, 18'h000, 0, 0, 0));
    vecs.push_back(mk("c26_br",   0, 0, 0, 1, 18'h1FF, 0, 1, 1, 0, 18'h000, 0, 0, 0));
    vecs.push_back(mk("c27_rrst", 1, 0, 0, 0, 18'h000, 0, 1, 1, 1, 18'h1FF, 1, 0, 1));
    vecs.push_back(mk("c28_idle", 0, 0, 0, 0, 18'h000, 0, 1, 0, 0, 18'h000, 0, 0, 0));
    vecs.push_back(mk("c29_idle", 0, 0, 0, 0, 18'h000, 0, 1, 0, 0, 18'h000, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Stall ignored in REDIRECT but honoured in FLUSH; halt wins in REDIRECT.
    apply(mk("h0_start",  0, 1, 0, 0, 18'h000, 0, 1, 0, 0, 18'h000, 0, 0, 0));
    apply(mk("h1_br",     0, 0, 0, 1, 18'h055, 0, 1, 1, 0, 18'h000, 0, 0, 0));
    apply(mk("h2_rd_stl", 0, 0, 1, 0, 18'h000, 0, 1, 1, 1, 18'h055, 1, 0, 1));
    apply(mk("h3_fl_stl", 0, 0, 1, 0, 18'h000, 0, 1, 0, 0, 18'h055, 1, 0, 2));
    apply(mk("h4_br",     0, 0, 0, 1, 18'h066, 0, 1, 1, 0, 18'h055, 0, 0, 2));
    apply(mk("h5_rd_hlt", 0, 0, 0, 1, 18'h077, 1, 1, 1, 1, 18'h066, 1, 0, 3));
    apply(mk("h6_halt",   0, 0, 0, 0, 18'h000, 0, 1, 0, 0, 18'h066, 0, 1, 4));
    apply(mk("h7_hrst",   1, 0, 0, 0, 18'h000, 0, 1, 0, 0, 18'h066, 0, 1, 4));
    apply(mk("h8_idle",   0, 0, 0, 0, 18'h000, 0, 1, 0, 0, 18'h000, 0, 0, 0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
